// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, FSM state encoding and
// the bit positions of the instruction fields.
package cu_pkg;

    // FSM state encoding; the fourth code is never entered and falls back to FETCH.
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } cu_state_e;

    // Opcodes. Any opcode with bit 3 set is an ALU operation.
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_JMP   = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BC    = 4'd5;
    localparam logic [3:0] OP_IN    = 4'd6;
    localparam logic [3:0] OP_OUT   = 4'd7;

    // Instruction field slices: {opcode, dst, a, b}.
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int DST_MSB    = 11;
    localparam int DST_LSB    = 8;
    localparam int FA_MSB     = 7;
    localparam int FA_LSB     = 4;
    localparam int FB_MSB     = 3;
    localparam int FB_LSB     = 0;
    localparam int ALU_OP_MSB = 14;
    localparam int ALU_OP_LSB = 12;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// 16-entry register file: two combinational read ports, one synchronous
// write port and a synchronous clear that overrides the write.
module cu_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [3:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        raddr0_i,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic [3:0]        raddr1_i,
    output logic [DATA_W-1:0] rdata1_o
);

    logic [DATA_W-1:0] regs_q [16];

    // Clear all registers or perform the single write.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = regs_q[raddr0_i];
    assign rdata1_o = regs_q[raddr1_i];

endmodule

// File: rtl/control_unit_param.sv
// Multi-cycle control unit: FETCH latches an instruction and its operands,
// EXEC drives memory / PC / GPIO side effects for one cycle.
// Optional feature macro CU_MEM_WAIT_EN: LOAD/STORE stall in MEM_WAIT until
// sram_ready; when undefined, sram_ready is ignored.
module control_unit_param
    import cu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 12,
    parameter int NUM_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 instruction,
    input  logic                        instr_valid,
    input  logic [DATA_W-1:0]           sram_read_data,
    input  logic                        sram_ready,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        equal,
    input  logic                        carry_out,
    input  logic [DATA_W-1:0]           in_gpio,
    input  logic                        bootstrapping,
    output logic [2:0]                  alu_opcode,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic                        sram_rd_en,
    output logic                        sram_write_en,
    output logic [7:0]                  sram_addr,
    output logic [DATA_W-1:0]           sram_write_data,
    output logic                        pc_load,
    output logic [PC_W-1:0]             pc_next,
    output logic                        pc_inc,
    output logic [NUM_PORTS*DATA_W-1:0] out_gpio,
    output logic [NUM_PORTS-1:0]        out_strobe,
    output logic [1:0]                  state
);

    cu_state_e                   state_q;
    logic [3:0]                  op_q, dst_q, a_q, b_q;
    logic [2:0]                  alu_opcode_q;
    logic [DATA_W-1:0]           alu_a_q, alu_b_q;
    logic                        zf_q, cf_q;
    logic [NUM_PORTS*DATA_W-1:0] out_gpio_q;
    logic [NUM_PORTS-1:0]        out_strobe_q;

    logic [3:0]        rd_addr0;
    logic [DATA_W-1:0] rd_data0, rd_data1;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              acc_done;
    logic              mem_op;
    logic              in_access;
    logic              finish_exec;
    logic [3:0]        port_sel;
    logic [PC_W-1:0]   pc_target;
    logic [DATA_W-1:0] imm_ext;

`ifdef CU_MEM_WAIT_EN
    assign acc_done = sram_ready;
`else
    logic unused_sram_ready;
    assign unused_sram_ready = sram_ready;
    assign acc_done          = 1'b1;
`endif

    // During FETCH port 0 reads operand a of the incoming word; later it reads dst.
    assign rd_addr0 = (state_q == ST_FETCH) ? instruction[FA_MSB:FA_LSB] : dst_q;

    cu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .clr_i    (rst),
        .we_i     (rf_we),
        .waddr_i  (dst_q),
        .wdata_i  (rf_wdata),
        .raddr0_i (rd_addr0),
        .rdata0_o (rd_data0),
        .raddr1_i (instruction[FB_MSB:FB_LSB]),
        .rdata1_o (rd_data1)
    );

    assign mem_op    = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign in_access = (state_q == ST_EXEC) || (state_q == ST_MEM_WAIT);
    assign port_sel  = b_q & 4'(NUM_PORTS - 1);

    // The instruction retires when EXEC needs no wait, or when the wait ends.
    assign finish_exec = ((state_q == ST_EXEC) && (!mem_op || acc_done)) ||
                         ((state_q == ST_MEM_WAIT) && acc_done);

    // Zero-extended jump target and IN immediate.
    always_comb begin
        pc_target       = '0;
        pc_target[11:0] = {dst_q, a_q, b_q};
        imm_ext         = '0;
        imm_ext[7:0]    = {a_q, b_q};
    end

    // Register-file write selection for LOAD, IN and ALU results.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_result;
        if (finish_exec) begin
            if (op_q == OP_LOAD) begin
                rf_we    = 1'b1;
                rf_wdata = sram_read_data;
            end else if (op_q == OP_IN) begin
                rf_we    = 1'b1;
                rf_wdata = bootstrapping ? imm_ext : in_gpio;
            end else if (is_alu_op(op_q)) begin
                rf_we    = 1'b1;
                rf_wdata = alu_result;
            end
        end
    end

    // Combinational EXEC outputs; enables are dropped while reset is asserted
    // so an access in flight is abandoned without a write.
    always_comb begin
        pc_inc          = (state_q == ST_FETCH) && instr_valid;
        pc_load         = 1'b0;
        pc_next         = '0;
        sram_rd_en      = 1'b0;
        sram_write_en   = 1'b0;
        sram_addr       = '0;
        sram_write_data = '0;
        if (in_access) begin
            sram_addr = {a_q, b_q};
            if (op_q == OP_LOAD) begin
                sram_rd_en = !rst;
            end
            if (op_q == OP_STORE) begin
                sram_write_en   = !rst;
                sram_write_data = rd_data0;
            end
        end
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_JMP:  pc_load = 1'b1;
                OP_BEQ:  pc_load = zf_q;
                OP_BC:   pc_load = cf_q;
                default: pc_load = 1'b0;
            endcase
            if (pc_load) begin
                pc_next = pc_target;
            end
        end
    end

    // Main FSM with registered operands, flags and GPIO outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            op_q         <= '0;
            dst_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            zf_q         <= 1'b0;
            cf_q         <= 1'b0;
            out_gpio_q   <= '0;
            out_strobe_q <= '0;
        end else begin
            out_strobe_q <= '0;
            case (state_q)
                ST_FETCH: begin
                    if (instr_valid) begin
                        op_q         <= instruction[OPC_MSB:OPC_LSB];
                        dst_q        <= instruction[DST_MSB:DST_LSB];
                        a_q          <= instruction[FA_MSB:FA_LSB];
                        b_q          <= instruction[FB_MSB:FB_LSB];
                        alu_opcode_q <= instruction[ALU_OP_MSB:ALU_OP_LSB];
                        alu_a_q      <= rd_data0;
                        alu_b_q      <= rd_data1;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (mem_op && !acc_done) begin
                        state_q <= ST_MEM_WAIT;
                    end else begin
                        if (is_alu_op(op_q)) begin
                            zf_q <= equal;
                            cf_q <= carry_out;
                        end
                        if (op_q == OP_OUT) begin
                            for (int k = 0; k < NUM_PORTS; k++) begin
                                if (4'(k) == port_sel) begin
                                    out_gpio_q[k*DATA_W +: DATA_W] <= rd_data0;
                                    out_strobe_q[k]                <= 1'b1;
                                end
                            end
                        end
                        state_q <= ST_FETCH;
                    end
                end
                ST_MEM_WAIT: begin
                    if (acc_done) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_gpio   = out_gpio_q;
    assign out_strobe = out_strobe_q;
    assign state      = state_q;

endmodule
